// File: rtl/krz_gpio.sv
// krz_gpio: memory-mapped GPIO slave (OUT/DIR/IN/TGL); ack one cycle after req, one transaction per 2 cycles.
// No backpressure beyond the handshake: a req held across its ack is served again only after ack drops.
module krz_gpio #(
  parameter int           N         = 8,
  parameter logic [N-1:0] OUT_RESET = N'(8'hFF),
  parameter logic [N-1:0] DIR_RESET = N'(8'hFF)
) (
  input  logic         clk,
  input  logic         rstz,
  input  logic [3:0]   gpio_addr,
  input  logic [31:0]  gpio_wr_data,
  input  logic [3:0]   gpio_mask,
  input  logic         gpio_wr_en,
  input  logic         gpio_req,
  output logic         gpio_ack,
  output logic [31:0]  gpio_rd_data,
  input  logic [N-1:0] gpio_in,
  output logic [N-1:0] gpio_out,
  output logic [N-1:0] gpio_oe
);

  typedef enum logic {IDLE, ACK} state_t;

  state_t      state;
  logic [N-1:0] out_q;
  logic [N-1:0] dir_q;
  logic [N-1:0] sync1;
  logic [N-1:0] sync2;
  logic [N-1:0] bit_en;
  logic [N-1:0] wdat;
  logic [31:0]  rd_q;
  logic [31:0]  rd_next;

  // Each GPIO bit is written only when the byte lane that carries it is enabled.
  for (genvar b = 0; b < N; b++) begin : g_ben
    assign bit_en[b] = gpio_mask[b / 8];
  end

  assign wdat = gpio_wr_data[N-1:0];

  always_comb begin
    rd_next = '0;
    case (gpio_addr[3:2])
      2'd0:    rd_next[N-1:0] = out_q;
      2'd1:    rd_next[N-1:0] = dir_q;
      2'd2:    rd_next[N-1:0] = sync2;
      default: rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state <= IDLE;
      out_q <= OUT_RESET;
      dir_q <= DIR_RESET;
      rd_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gpio_req) begin
            state <= ACK;
            rd_q  <= rd_next;
            if (gpio_wr_en) begin
              case (gpio_addr[3:2])
                2'd0:    out_q <= (out_q & ~bit_en) | (wdat & bit_en);
                2'd1:    dir_q <= (dir_q & ~bit_en) | (wdat & bit_en);
                2'd3:    out_q <= out_q ^ (wdat & bit_en);
                default: ;
              endcase
            end
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign gpio_ack     = (state == ACK);
  assign gpio_rd_data = rd_q;
  assign gpio_out     = out_q;
  assign gpio_oe      = dir_q;

endmodule

// File: doc/krz_gpio.md
Name: krz_gpio

Overview:
- Memory-mapped GPIO slave on the Kronos core data bus inside krz_top; the stage downstream of the core's load/store port.
- Drives board LED pins (LEDR, LEDG) and other pads from core register writes.
- Samples input pads through a 2-flop synchronizer.
- Single-cycle request/ack handshake matching the core data bus.

Parameters:
N, 8, number of GPIO lines (1..32)
OUT_RESET, 8'hFF, reset value of the output register (LEDs are active-low, so the default is all off)
DIR_RESET, 8'hFF, reset value of the direction register (1 = output)

Ports:
clk  in  1  core clock
rstz  in  1  asynchronous active-low reset
gpio_addr  in  4  word-aligned register offset within the GPIO window (byte address bits [3:0])
gpio_wr_data  in  32  write data
gpio_mask  in  4  byte-enable for writes
gpio_wr_en  in  1  1 = write, 0 = read
gpio_req  in  1  bus request
gpio_ack  out  1  bus acknowledge
gpio_rd_data  out  32  read data, valid with gpio_ack
gpio_in  in  N  raw input pads (asynchronous)
gpio_out  out  N  output pad values
gpio_oe  out  N  output enables (mirror of the DIR register)

Behaviour:
- Reset state (rstz low, asynchronous):
  - OUT = OUT_RESET, DIR = DIR_RESET.
  - Synchronizer flops are 0.
  - gpio_ack = 0, gpio_rd_data = 0.
- Register map (offset: name):
  - 0x0 OUT: R/W.
  - 0x4 DIR: R/W.
  - 0x8 IN: read-only; writes are ignored and still acked.
  - 0xC TGL: write-only; XORs wr_data into OUT; reads return 0.
  - All registers are N bits wide; bits [31:N] read as 0.
- Handshake:
  - On a cycle with gpio_req=1 and gpio_ack=0, gpio_ack asserts on the next posedge for exactly one cycle.
  - A req held high across the ack cycle does not produce a second ack on that same cycle; ack goes 0 for one cycle, then the next request is served. Maximum throughput is one transaction every 2 cycles.
  - The write side-effect commits on the same edge that raises gpio_ack.
  - gpio_rd_data is registered on that same edge and held until the next ack; outside ack it holds its last value.
- Byte masking:
  - A write updates only bytes with gpio_mask[i]=1; bytes at or above N are ignored.
  - A write with mask=0 performs no update but is still acked.
  - TGL honours the mask the same way.
- Input path: gpio_in passes through two flops on clk. An IN read returns the second-stage value as it stood before the ack edge, so a pad change becomes visible at most 3 cycles later.
- Outputs:
  - gpio_out = OUT register, registered, with no combinational path from the bus.
  - gpio_oe = DIR register.
  - With an input-configured line (DIR bit 0), gpio_out still reflects OUT; the pad layer gates it with oe.
- Address decode: gpio_addr[1:0] is ignored (word access only).
- Simultaneous events: a write to OUT and an IN change in the same cycle are independent. The IN synchronizer runs every cycle regardless of bus activity.
- Reset mid-transaction: rstz low aborts the transaction; ack drops immediately (asynchronously). No write commits unless its ack edge completed before reset assertion.
- State machine, 2 states:
  - IDLE: req → ACK, performing the commit/read on this edge.
  - ACK: unconditionally → IDLE.
  - gpio_ack = (state == ACK).

Test Plan:
1. Reset: hold rstz=0 for 4 cycles, release → gpio_out=8'hFF, gpio_oe=8'hFF, gpio_ack=0; a read of 0x0 returns 32'h000000FF one cycle after req.
2. Write OUT=32'h0000_00FE with mask=4'b0001 → ack 1 cycle after req; gpio_out[0]=0 (LED on) on the same edge; readback of 0x0 = 32'hFE.
3. TGL: write 0xC with 32'h03 three times with req held continuously → acks on cycles 1, 3, 5 (no back-to-back ack); gpio_out alternates FC, FF, FC.
4. Input sync: drive gpio_in=8'hA5 at cycle t; read IN issued at t+0 returns the old value, read issued at t+2 returns 32'hA5; bits [31:8] = 0.
5. Mask/ignore: write 0x0 with 32'h1234_5600 and mask=4'b1110 → OUT is unchanged (bytes above N are dropped); write to IN is acked and IN is unchanged.
6. Reset mid-op: assert rstz low in the cycle req rises → no ack, OUT=OUT_RESET after release; the next request completes normally.
